// File: rtl/demux_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// demux_rr_scheduler_if : upstream stream and 1:N demux output handshake
// Rev 1.0
// ============================================================================
interface demux_rr_scheduler_if #(
   parameter int N_OUT  = 4,
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic [N_OUT-1:0]  out_ready;
   logic [N_OUT-1:0]  out_valid;
   logic [DATA_W-1:0] out_data;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface
`default_nettype wire

// File: rtl/demux_rr_scheduler.sv
`default_nettype none
// ============================================================================
// demux_rr_scheduler : round-robin burst scheduler for a 1:N demux stage.
// Optional stall abort enabled by DEMUX_SCHED_TIMEOUT_EN.  Rev 1.0
// ============================================================================
module demux_rr_scheduler #(
   parameter int N_OUT     = 4,
   parameter int SEL_W     = 2,
   parameter int DATA_W    = 8,
   parameter int BURST_LEN = 4,
   parameter int TIMEOUT   = 16
) (
   input  wire logic             clk,
   input  wire logic             rst,
   demux_rr_scheduler_if.slave   bus,
   output logic [SEL_W-1:0]      sel,
   output logic                  busy
`ifdef DEMUX_SCHED_TIMEOUT_EN
   ,
   output logic                  timeout_pulse
`endif
);

   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_XFER = 2'd2
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [SEL_W-1:0]   r_sel, w_sel_nxt;
   logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
   logic [CNT_W-1:0]   r_beat_cnt, w_cnt_nxt;
   logic               w_found;
   logic [SEL_W-1:0]   w_pick;
   logic               w_beat;
   logic               w_abort;
   logic [N_OUT-1:0]   w_out_valid;

   function automatic logic [SEL_W-1:0] f_wrap(input int v);
      f_wrap = SEL_W'(v % N_OUT);
   endfunction

   // Search starts one past the last grant so the port just served ranks last.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int i = 1; i <= N_OUT; i++) begin
         if (!w_found && bus.out_ready[f_wrap(int'(r_ptr) + i)]) begin
            w_found = 1'b1;
            w_pick  = f_wrap(int'(r_ptr) + i);
         end
      end
   end

   assign w_beat = (r_state == ST_XFER) && bus.in_valid && bus.out_ready[r_sel];

`ifdef DEMUX_SCHED_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT + 1);
   localparam logic [STALL_W-1:0] c_stall_last = STALL_W'(TIMEOUT - 1);

   logic [STALL_W-1:0] r_stall, w_stall_nxt;
   logic               w_stalling;

   assign w_stalling = (r_state == ST_XFER) && bus.in_valid && !bus.out_ready[r_sel];
   assign w_abort    = w_stalling && (r_stall == c_stall_last);

   always_comb begin
      w_stall_nxt = r_stall;
      if (r_state != ST_XFER || w_beat || w_abort) begin
         w_stall_nxt = '0;
      end else if (w_stalling) begin
         w_stall_nxt = r_stall + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall <= '0;
      end else begin
         r_stall <= w_stall_nxt;
      end
   end

   assign timeout_pulse = w_abort;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT > 0);
   assign w_abort          = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_beat_cnt;
      case (r_state)
         ST_IDLE: begin
            if (bus.in_valid) begin
               w_state_nxt = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (!bus.in_valid) begin
               w_state_nxt = ST_IDLE;
            end else if (w_found) begin
               w_sel_nxt   = w_pick;
               w_ptr_nxt   = w_pick;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_XFER;
            end
         end
         ST_XFER: begin
            if (w_beat) begin
               if (r_beat_cnt == c_last_beat) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = bus.in_valid ? ST_SCAN : ST_IDLE;
               end else begin
                  w_cnt_nxt = r_beat_cnt + 1'b1;
               end
            end else if (w_abort) begin
               // Stalled port is demoted to lowest priority for the rescan.
               w_ptr_nxt   = r_sel;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_SCAN;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_sel      <= '0;
         r_ptr      <= SEL_W'(N_OUT - 1);
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_sel      <= w_sel_nxt;
         r_ptr      <= w_ptr_nxt;
         r_beat_cnt <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_out_valid = '0;
      if (r_state == ST_XFER && bus.in_valid) begin
         w_out_valid[r_sel] = 1'b1;
      end
   end

   assign bus.out_valid = w_out_valid;
   assign bus.in_ready  = (r_state == ST_XFER) && bus.out_ready[r_sel];
   assign bus.out_data  = bus.in_data;
   assign sel           = r_sel;
   assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire
